// File: rtl/encoder_snapshot_ctrl_pkg.sv
// rtl/encoder_snapshot_ctrl_pkg.sv - register map, bit positions, FSM encoding and count constants
package encoder_snapshot_ctrl_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_PERIOD = 4'd2;
  localparam logic [3:0] ADDR_SEQ    = 4'd3;

  // address[3:2] selects the register bank, address[1:0] the channel
  localparam logic [1:0] BANK_MISC  = 2'b00;
  localparam logic [1:0] BANK_POS   = 2'b01;
  localparam logic [1:0] BANK_DELTA = 2'b10;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT     = 1;
  localparam int CTRL_SOFT_TICK_BIT  = 2;
  localparam int STATUS_READY_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT  = 1;
  localparam int STATUS_BUSY_BIT     = 2;

  localparam int          MAX_CH     = 4;
  localparam logic [31:0] COUNT_RST  = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_PERIOD = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DIFF    = 2'd2,
    ST_READY   = 2'd3
  } state_t;

endpackage

// File: rtl/encoder_snapshot_ctrl_if.sv
// rtl/encoder_snapshot_ctrl_if.sv - Avalon-MM register port
interface encoder_snapshot_ctrl_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/servo_tick_timer.sv
// rtl/servo_tick_timer.sv - servo period tick generator, restarts from 0 on reload or disable
module servo_tick_timer
  import encoder_snapshot_ctrl_pkg::*;
(
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        reload,
  output logic        tick
);

  logic [31:0] timer_q;
  logic [31:0] limit;

  assign limit = ((period < MIN_PERIOD) ? MIN_PERIOD : period) - 32'd1;
  assign tick  = enable && (timer_q == limit);

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (!enable || reload || tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

endmodule

// File: rtl/encoder_snapshot_ctrl.sv
// rtl/encoder_snapshot_ctrl.sv - coherent multi-channel encoder snapshot with per-channel deltas
module encoder_snapshot_ctrl
  import encoder_snapshot_ctrl_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int unsigned PERIOD_RST = 50000
) (
  input  logic                  clk50,
  input  logic                  reset_n,
  input  logic [32*NUM_CH-1:0]  count_in,
  encoder_snapshot_ctrl_if.slave bus,
  output logic                  irq
);

  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  state_t state_q, state_d;
  logic        enable_q, irq_en_q, overrun_q;
  logic [31:0] period_q, seq_q;
  logic [31:0] pos_q   [MAX_CH];
  logic [31:0] prev_q  [MAX_CH];
  logic [31:0] delta_q [MAX_CH];
  logic [1:0]  ch_idx_q;
  logic [32*MAX_CH-1:0] count_pad;

  logic wr_ctrl, wr_status, wr_period;
  logic timer_tick, tick, ack, overrun_set, overrun_clr;
  logic busy, ready, capture, diff_step;
  logic [31:0] diff, rd_mux;
  logic [1:0]  rd_ch;

  assign count_pad   = (32*MAX_CH)'(count_in);
  assign wr_ctrl     = bus.write && (bus.address == ADDR_CTRL);
  assign wr_status   = bus.write && (bus.address == ADDR_STATUS);
  assign wr_period   = bus.write && (bus.address == ADDR_PERIOD);
  assign tick        = timer_tick || (wr_ctrl && bus.writedata[CTRL_SOFT_TICK_BIT]);
  assign ack         = wr_status && bus.writedata[STATUS_READY_BIT];
  assign overrun_clr = wr_status && bus.writedata[STATUS_OVERRUN_BIT];
  assign overrun_set = tick && (state_q != ST_IDLE);
  assign ready       = (state_q == ST_READY);
  assign irq         = ready && irq_en_q;
  assign diff        = pos_q[ch_idx_q] - prev_q[ch_idx_q];

  servo_tick_timer u_timer (
    .clk50   (clk50),
    .reset_n (reset_n),
    .enable  (enable_q),
    .period  (period_q),
    .reload  (wr_period),
    .tick    (timer_tick)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable is deliberately not consulted here: a started sequence always completes
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    capture   = 1'b0;
    diff_step = 1'b0;
    case (state_q)
      ST_IDLE:    if (tick) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        busy    = 1'b1;
        capture = 1'b1;
        state_d = ST_DIFF;
      end
      ST_DIFF: begin
        busy      = 1'b1;
        diff_step = 1'b1;
        if (ch_idx_q == LAST_CH) state_d = ST_READY;
      end
      ST_READY:   if (ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      overrun_q <= 1'b0;
      period_q  <= 32'(PERIOD_RST);
      seq_q     <= '0;
      ch_idx_q  <= '0;
      for (int i = 0; i < MAX_CH; i++) begin
        pos_q[i]   <= COUNT_RST;
        prev_q[i]  <= COUNT_RST;
        delta_q[i] <= '0;
      end
    end else begin
      if (wr_ctrl) begin
        enable_q <= bus.writedata[CTRL_ENABLE_BIT];
        irq_en_q <= bus.writedata[CTRL_IRQ_EN_BIT];
      end
      if (wr_period) period_q <= bus.writedata;
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
      if (capture) begin
        for (int i = 0; i < MAX_CH; i++) begin
          if (i < NUM_CH) begin
            pos_q[i]  <= count_pad[32*i +: 32];
            prev_q[i] <= pos_q[i];
          end
        end
        seq_q    <= seq_q + 32'd1;
        ch_idx_q <= '0;
      end
      if (diff_step) begin
        delta_q[ch_idx_q] <= diff;
        ch_idx_q          <= ch_idx_q + 2'd1;
      end
    end
  end

  assign rd_ch = bus.address[1:0];

  always_comb begin
    rd_mux = '0;
    case (bus.address[3:2])
      BANK_MISC: begin
        case (bus.address)
          ADDR_CTRL: begin
            rd_mux[CTRL_ENABLE_BIT] = enable_q;
            rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
          end
          ADDR_STATUS: begin
            rd_mux[STATUS_READY_BIT]   = ready;
            rd_mux[STATUS_OVERRUN_BIT] = overrun_q;
            rd_mux[STATUS_BUSY_BIT]    = busy;
          end
          ADDR_PERIOD: rd_mux = period_q;
          ADDR_SEQ:    rd_mux = seq_q;
          default:     rd_mux = '0;
        endcase
      end
      BANK_POS:   if (int'(rd_ch) < NUM_CH) rd_mux = pos_q[rd_ch];
      BANK_DELTA: if (int'(rd_ch) < NUM_CH) rd_mux = delta_q[rd_ch];
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else if (bus.read) begin
      bus.readdata <= rd_mux;
    end
  end

endmodule
